// File: rtl/axi_pkg.sv
// Shared AXI3 encodings, engine state type and response-severity helper.
package axi_pkg;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam logic [1:0] LOCK_NORMAL   = 2'b00;
   localparam logic [3:0] CACHE_DEFAULT = 4'b0000;
   localparam logic [2:0] PROT_NORMAL   = 3'b000;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_AW,
      ST_W,
      ST_B,
      ST_AR,
      ST_R,
      ST_RSP
   } state_e;

   // DECERR outranks SLVERR, which outranks the OKAY family.
   function automatic logic [1:0] respSeverity(input logic [1:0] resp);
      logic [1:0] sev;
      sev = 2'd0;
      if (resp == RESP_DECERR) sev = 2'd2;
      else if (resp == RESP_SLVERR) sev = 2'd1;
      return sev;
   endfunction

   function automatic logic [1:0] worstResp(input logic [1:0] a, input logic [1:0] b);
      return (respSeverity(b) > respSeverity(a)) ? b : a;
   endfunction

endpackage

// File: rtl/axi_master_engine_if.sv
// Bundles the command, data-stream, response and AXI3 channel signals of the engine.
interface axi_master_engine_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int ID_WIDTH   = 4
);
   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   logic                  cmd_valid;
   logic                  cmd_ready;
   logic                  cmd_write;
   logic [ID_WIDTH-1:0]   cmd_id;
   logic [ADDR_WIDTH-1:0] cmd_addr;
   logic [3:0]            cmd_len;
   logic [2:0]            cmd_size;
   logic [1:0]            cmd_burst;

   logic                  wd_valid;
   logic                  wd_ready;
   logic [DATA_WIDTH-1:0] wd_data;
   logic [STRB_WIDTH-1:0] wd_strb;

   logic                  rd_valid;
   logic                  rd_ready;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  rd_last;

   logic                  rsp_valid;
   logic                  rsp_ready;
   logic                  rsp_write;
   logic [1:0]            rsp_resp;
   logic                  rsp_err;

   logic [ID_WIDTH-1:0]   awid;
   logic [ADDR_WIDTH-1:0] awaddr;
   logic [3:0]            awlen;
   logic [2:0]            awsize;
   logic [1:0]            awburst;
   logic [1:0]            awlock;
   logic [3:0]            awcache;
   logic [2:0]            awprot;
   logic                  awvalid;
   logic                  awready;

   logic [ID_WIDTH-1:0]   wid;
   logic [DATA_WIDTH-1:0] wdata;
   logic [STRB_WIDTH-1:0] wstrb;
   logic                  wlast;
   logic                  wvalid;
   logic                  wready;

   logic [ID_WIDTH-1:0]   bid;
   logic [1:0]            bresp;
   logic                  bvalid;
   logic                  bready;

   logic [ID_WIDTH-1:0]   arid;
   logic [ADDR_WIDTH-1:0] araddr;
   logic [3:0]            arlen;
   logic [2:0]            arsize;
   logic [1:0]            arburst;
   logic [1:0]            arlock;
   logic [3:0]            arcache;
   logic [2:0]            arprot;
   logic                  arvalid;
   logic                  arready;

   logic [ID_WIDTH-1:0]   rid;
   logic [DATA_WIDTH-1:0] rdata;
   logic [1:0]            rresp;
   logic                  rlast;
   logic                  rvalid;
   logic                  rready;

   modport master (
      input  cmd_valid, cmd_write, cmd_id, cmd_addr, cmd_len, cmd_size, cmd_burst,
      output cmd_ready,
      input  wd_valid, wd_data, wd_strb,
      output wd_ready,
      output rd_valid, rd_data, rd_last,
      input  rd_ready,
      output rsp_valid, rsp_write, rsp_resp, rsp_err,
      input  rsp_ready,
      output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
      input  awready,
      output wid, wdata, wstrb, wlast, wvalid,
      input  wready,
      input  bid, bresp, bvalid,
      output bready,
      output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
      input  arready,
      input  rid, rdata, rresp, rlast, rvalid,
      output rready
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_id, cmd_addr, cmd_len, cmd_size, cmd_burst,
      input  cmd_ready,
      output wd_valid, wd_data, wd_strb,
      input  wd_ready,
      input  rd_valid, rd_data, rd_last,
      output rd_ready,
      input  rsp_valid, rsp_write, rsp_resp, rsp_err,
      output rsp_ready,
      input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
      output awready,
      input  wid, wdata, wstrb, wlast, wvalid,
      output wready,
      output bid, bresp, bvalid,
      input  bready,
      input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
      output arready,
      output rid, rdata, rresp, rlast, rvalid,
      input  rready
   );

endinterface

// File: rtl/axi_master_engine.sv
// Single-outstanding AXI3 master: latches one command, runs AW/W/B or AR/R, reports completion.
module axi_master_engine
   import axi_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int ID_WIDTH   = 4
) (
   input  logic                aclk,
   input  logic                aresetn,
   axi_master_engine_if.master bus,
   output logic                err_sticky
);

   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   state_e                state_q, state_d;
   logic                  readyEn_q, readyEn_d;
   logic                  write_q, write_d;
   logic [ID_WIDTH-1:0]   id_q, id_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [3:0]            len_q, len_d;
   logic [2:0]            size_q, size_d;
   logic [1:0]            burst_q, burst_d;
   logic [3:0]            beatCnt_q, beatCnt_d;
   logic [1:0]            resp_q, resp_d;
   logic                  err_q, err_d;
   logic                  sticky_q, sticky_d;
   logic                  rspErr;
   logic                  lastBeat;

   assign rspErr   = err_q | (resp_q != RESP_OKAY);
   assign lastBeat = (beatCnt_q == len_q);

   // State and datapath registers; reset aborts any burst and clears every latched field.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state_q   <= ST_IDLE;
         readyEn_q <= 1'b0;
         write_q   <= 1'b0;
         id_q      <= '0;
         addr_q    <= '0;
         len_q     <= '0;
         size_q    <= '0;
         burst_q   <= '0;
         beatCnt_q <= '0;
         resp_q    <= RESP_OKAY;
         err_q     <= 1'b0;
         sticky_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         readyEn_q <= readyEn_d;
         write_q   <= write_d;
         id_q      <= id_d;
         addr_q    <= addr_d;
         len_q     <= len_d;
         size_q    <= size_d;
         burst_q   <= burst_d;
         beatCnt_q <= beatCnt_d;
         resp_q    <= resp_d;
         err_q     <= err_d;
         sticky_q  <= sticky_d;
      end
   end

   // Next-state logic: channel sequencing, beat counting and worst-response merge.
   always_comb begin
      state_d   = state_q;
      readyEn_d = 1'b1;
      write_d   = write_q;
      id_d      = id_q;
      addr_d    = addr_q;
      len_d     = len_q;
      size_d    = size_q;
      burst_d   = burst_q;
      beatCnt_d = beatCnt_q;
      resp_d    = resp_q;
      err_d     = err_q;
      sticky_d  = sticky_q | ((state_q == ST_RSP) & rspErr);
      unique case (state_q)
         ST_IDLE: begin
            if (bus.cmd_valid && readyEn_q) begin
               write_d   = bus.cmd_write;
               id_d      = bus.cmd_id;
               addr_d    = bus.cmd_addr;
               len_d     = bus.cmd_len;
               size_d    = bus.cmd_size;
               burst_d   = bus.cmd_burst;
               beatCnt_d = '0;
               resp_d    = RESP_OKAY;
               err_d     = 1'b0;
               state_d   = bus.cmd_write ? ST_AW : ST_AR;
            end
         end
         ST_AW: begin
            if (bus.awready) state_d = ST_W;
         end
         ST_W: begin
            if (bus.wd_valid && bus.wready) begin
               if (lastBeat) begin
                  beatCnt_d = '0;
                  state_d   = ST_B;
               end else begin
                  beatCnt_d = beatCnt_q + 4'd1;
               end
            end
         end
         ST_B: begin
            if (bus.bvalid) begin
               resp_d = worstResp(resp_q, bus.bresp);
               if (bus.bid != id_q) err_d = 1'b1;
               state_d = ST_RSP;
            end
         end
         ST_AR: begin
            if (bus.arready) state_d = ST_R;
         end
         ST_R: begin
            if (bus.rvalid && bus.rd_ready) begin
               resp_d = worstResp(resp_q, bus.rresp);
               if (bus.rlast != lastBeat) err_d = 1'b1;
               if (lastBeat) begin
                  beatCnt_d = '0;
                  state_d   = ST_RSP;
               end else begin
                  beatCnt_d = beatCnt_q + 4'd1;
               end
            end
         end
         ST_RSP: begin
            if (bus.rsp_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Output decode: registered command fields on AW/AR, gated pass-through on the data streams.
   always_comb begin
      bus.cmd_ready = (state_q == ST_IDLE) && readyEn_q;

      bus.awid    = id_q;
      bus.awaddr  = addr_q;
      bus.awlen   = len_q;
      bus.awsize  = size_q;
      bus.awburst = burst_q;
      bus.awlock  = LOCK_NORMAL;
      bus.awcache = CACHE_DEFAULT;
      bus.awprot  = PROT_NORMAL;
      bus.awvalid = (state_q == ST_AW);

      bus.arid    = id_q;
      bus.araddr  = addr_q;
      bus.arlen   = len_q;
      bus.arsize  = size_q;
      bus.arburst = burst_q;
      bus.arlock  = LOCK_NORMAL;
      bus.arcache = CACHE_DEFAULT;
      bus.arprot  = PROT_NORMAL;
      bus.arvalid = (state_q == ST_AR);

      bus.wid      = id_q;
      bus.wdata    = (state_q == ST_W) ? bus.wd_data : {DATA_WIDTH{1'b0}};
      bus.wstrb    = (state_q == ST_W) ? bus.wd_strb : {STRB_WIDTH{1'b0}};
      bus.wlast    = (state_q == ST_W) && lastBeat;
      bus.wvalid   = (state_q == ST_W) && bus.wd_valid;
      bus.wd_ready = (state_q == ST_W) && bus.wready;

      bus.bready = (state_q == ST_B);

      bus.rd_valid = (state_q == ST_R) && bus.rvalid;
      bus.rd_data  = (state_q == ST_R) ? bus.rdata : {DATA_WIDTH{1'b0}};
      bus.rd_last  = (state_q == ST_R) && lastBeat;
      bus.rready   = (state_q == ST_R) && bus.rd_ready;

      bus.rsp_valid = (state_q == ST_RSP);
      bus.rsp_write = write_q;
      bus.rsp_resp  = resp_q;
      bus.rsp_err   = rspErr;

      err_sticky = sticky_q | ((state_q == ST_RSP) & rspErr);
   end

endmodule

// File: tb/tb_axi_master_engine.sv
// Directed bench for axi_master_engine: bench plays command source, data streams and AXI slave.
module tb_axi_master_engine;
   import axi_pkg::*;

   logic aclk = 1'b0;
   logic aresetn;
   logic errSticky;
   int   checks = 0;
   int   failures = 0;
   int   beat;
   int   cyc;

   always #5 aclk = ~aclk;

   axi_master_engine_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .ID_WIDTH(4)) bus ();

   axi_master_engine #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .ID_WIDTH(4)) dut (
      .aclk       (aclk),
      .aresetn    (aresetn),
      .bus        (bus.master),
      .err_sticky (errSticky)
   );

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Presents one command for exactly one accepting edge.
   task automatic applyStimulus(input logic wr, input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len);
      bus.cmd_valid = 1'b1;
      bus.cmd_write = wr;
      bus.cmd_id    = id;
      bus.cmd_addr  = addr;
      bus.cmd_len   = len;
      bus.cmd_size  = 3'd2;
      bus.cmd_burst = BURST_INCR;
      tick();
      bus.cmd_valid = 1'b0;
   endtask

   task automatic startRead(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len, input string tag);
      applyStimulus(1'b0, id, addr, len);
      checkOutput({tag, ".arvalid"}, bus.arvalid, 1);
      checkOutput({tag, ".araddr"}, bus.araddr, addr);
      checkOutput({tag, ".arlen"}, bus.arlen, len);
      checkOutput({tag, ".arid"}, bus.arid, id);
      bus.arready = 1'b1;
      tick();
      bus.arready = 1'b0;
      bus.rid = id;
      bus.rd_ready = 1'b1;
   endtask

   task automatic readBeat(input logic [31:0] data, input logic [1:0] resp, input logic last,
                           input logic expLast, input string tag);
      bus.rvalid = 1'b1;
      bus.rdata  = data;
      bus.rresp  = resp;
      bus.rlast  = last;
      #1;
      checkOutput({tag, ".rd_valid"}, bus.rd_valid, 1);
      checkOutput({tag, ".rd_data"}, bus.rd_data, data);
      checkOutput({tag, ".rd_last"}, bus.rd_last, expLast);
      tick();
      bus.rvalid = 1'b0;
      bus.rlast  = 1'b0;
   endtask

   task automatic rspPhase(input logic expWrite, input logic [1:0] expResp, input logic expErr,
                           input logic expSticky, input string tag);
      checkOutput({tag, ".rsp_valid"}, bus.rsp_valid, 1);
      checkOutput({tag, ".rsp_write"}, bus.rsp_write, expWrite);
      checkOutput({tag, ".rsp_resp"}, bus.rsp_resp, expResp);
      checkOutput({tag, ".rsp_err"}, bus.rsp_err, expErr);
      checkOutput({tag, ".err_sticky"}, errSticky, expSticky);
      bus.rsp_ready = 1'b1;
      tick();
      bus.rsp_ready = 1'b0;
      checkOutput({tag, ".rsp_done"}, bus.rsp_valid, 0);
      checkOutput({tag, ".cmd_ready_next"}, bus.cmd_ready, 1);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired before the directed sequence ended");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      aresetn = 1'b0;
      bus.cmd_valid = 0; bus.cmd_write = 0; bus.cmd_id = 0; bus.cmd_addr = 0;
      bus.cmd_len = 0; bus.cmd_size = 0; bus.cmd_burst = 0;
      bus.wd_valid = 0; bus.wd_data = 0; bus.wd_strb = 0;
      bus.rd_ready = 0; bus.rsp_ready = 0;
      bus.awready = 0; bus.wready = 0; bus.arready = 0;
      bus.bid = 0; bus.bresp = 0; bus.bvalid = 0;
      bus.rid = 0; bus.rdata = 0; bus.rresp = 0; bus.rlast = 0; bus.rvalid = 0;

      // Reset state
      repeat (3) tick();
      checkOutput("rst.cmd_ready", bus.cmd_ready, 0);
      checkOutput("rst.awvalid", bus.awvalid, 0);
      checkOutput("rst.arvalid", bus.arvalid, 0);
      checkOutput("rst.wvalid", bus.wvalid, 0);
      checkOutput("rst.bready", bus.bready, 0);
      checkOutput("rst.rsp_valid", bus.rsp_valid, 0);
      checkOutput("rst.awaddr", bus.awaddr, 0);
      checkOutput("rst.err_sticky", errSticky, 0);
      aresetn = 1'b1;
      tick();
      checkOutput("rst.cmd_ready_rise", bus.cmd_ready, 1);

      // Single write, awready after two cycles
      applyStimulus(1'b1, 4'h3, 32'h100, 4'd0);
      bus.wd_valid = 1'b1; bus.wd_data = 32'hDEADBEEF; bus.wd_strb = 4'hF;
      #1;
      checkOutput("wr1.awvalid", bus.awvalid, 1);
      checkOutput("wr1.awaddr", bus.awaddr, 32'h100);
      checkOutput("wr1.awlen", bus.awlen, 0);
      checkOutput("wr1.awid", bus.awid, 3);
      checkOutput("wr1.awburst", bus.awburst, BURST_INCR);
      checkOutput("wr1.awlock", bus.awlock, LOCK_NORMAL);
      checkOutput("wr1.wvalid_before_aw", bus.wvalid, 0);
      checkOutput("wr1.cmd_ready_busy", bus.cmd_ready, 0);
      tick();
      checkOutput("wr1.awvalid_hold", bus.awvalid, 1);
      checkOutput("wr1.awaddr_hold", bus.awaddr, 32'h100);
      bus.awready = 1'b1;
      tick();
      bus.awready = 1'b0;
      #1;
      checkOutput("wr1.awvalid_done", bus.awvalid, 0);
      checkOutput("wr1.wvalid", bus.wvalid, 1);
      checkOutput("wr1.wdata", bus.wdata, 32'hDEADBEEF);
      checkOutput("wr1.wstrb", bus.wstrb, 4'hF);
      checkOutput("wr1.wlast", bus.wlast, 1);
      checkOutput("wr1.wid", bus.wid, 3);
      checkOutput("wr1.bready_in_w", bus.bready, 0);
      bus.wready = 1'b1;
      tick();
      bus.wready = 1'b0; bus.wd_valid = 1'b0;
      #1;
      checkOutput("wr1.bready", bus.bready, 1);
      checkOutput("wr1.wvalid_after", bus.wvalid, 0);
      bus.bvalid = 1'b1; bus.bid = 4'h3; bus.bresp = RESP_OKAY;
      tick();
      bus.bvalid = 1'b0;
      rspPhase(1'b1, RESP_OKAY, 1'b0, 1'b0, "wr1");

      // INCR4 read
      startRead(4'h5, 32'h200, 4'd3, "rd4");
      readBeat(32'h11, RESP_OKAY, 1'b0, 1'b0, "rd4.b0");
      readBeat(32'h22, RESP_OKAY, 1'b0, 1'b0, "rd4.b1");
      readBeat(32'h33, RESP_OKAY, 1'b0, 1'b0, "rd4.b2");
      readBeat(32'h44, RESP_OKAY, 1'b1, 1'b1, "rd4.b3");
      rspPhase(1'b0, RESP_OKAY, 1'b0, 1'b0, "rd4");

      // Backpressured 8-beat write with an early bvalid held during W
      applyStimulus(1'b1, 4'h6, 32'h300, 4'd7);
      bus.awready = 1'b1;
      tick();
      bus.awready = 1'b0;
      bus.bvalid = 1'b1; bus.bid = 4'h6; bus.bresp = RESP_OKAY;
      beat = 0;
      cyc = 0;
      while (beat < 8 && cyc < 100) begin
         bus.wd_valid = (cyc % 2 == 0);
         bus.wd_data  = 32'hA0 + beat;
         bus.wd_strb  = 4'hF;
         bus.wready   = !(cyc >= 2 && cyc <= 4);
         #1;
         checkOutput("bp.wvalid", bus.wvalid, bus.wd_valid);
         checkOutput("bp.bready_in_w", bus.bready, 0);
         if (bus.wd_valid) begin
            checkOutput("bp.wdata", bus.wdata, 32'hA0 + beat);
            checkOutput("bp.wlast", bus.wlast, (beat == 7));
         end
         if (bus.wd_valid && bus.wready) beat++;
         tick();
         cyc++;
      end
      bus.wd_valid = 1'b0; bus.wready = 1'b0;
      checkOutput("bp.within_budget", (cyc < 100), 1);
      #1;
      checkOutput("bp.bready", bus.bready, 1);
      checkOutput("bp.wvalid_after", bus.wvalid, 0);
      tick();
      bus.bvalid = 1'b0;
      rspPhase(1'b1, RESP_OKAY, 1'b0, 1'b0, "bp");

      // Error path: SLVERR then DECERR, sticky survives a clean read
      startRead(4'h2, 32'h400, 4'd1, "err");
      readBeat(32'h55, RESP_SLVERR, 1'b0, 1'b0, "err.b0");
      readBeat(32'h66, RESP_DECERR, 1'b1, 1'b1, "err.b1");
      rspPhase(1'b0, RESP_DECERR, 1'b1, 1'b1, "err");
      checkOutput("err.sticky_idle", errSticky, 1);
      startRead(4'h2, 32'h404, 4'd0, "ok");
      readBeat(32'h77, RESP_OKAY, 1'b1, 1'b1, "ok.b0");
      rspPhase(1'b0, RESP_OKAY, 1'b0, 1'b1, "ok");

      // rlast on beat 2 of a 4-beat read
      startRead(4'h7, 32'h500, 4'd3, "rl");
      readBeat(32'h1, RESP_OKAY, 1'b0, 1'b0, "rl.b0");
      readBeat(32'h2, RESP_OKAY, 1'b1, 1'b0, "rl.b1");
      readBeat(32'h3, RESP_OKAY, 1'b0, 1'b0, "rl.b2");
      readBeat(32'h4, RESP_OKAY, 1'b0, 1'b1, "rl.b3");
      rspPhase(1'b0, RESP_OKAY, 1'b1, 1'b1, "rl");

      // Reset during beat 2 of an INCR4 write
      applyStimulus(1'b1, 4'h9, 32'h600, 4'd3);
      bus.awready = 1'b1;
      tick();
      bus.awready = 1'b0;
      bus.wd_valid = 1'b1; bus.wd_data = 32'hC0; bus.wd_strb = 4'hF; bus.wready = 1'b1;
      tick();
      bus.wd_data = 32'hC1;
      #1;
      checkOutput("mid.wvalid_beat2", bus.wvalid, 1);
      checkOutput("mid.wlast_beat2", bus.wlast, 0);
      aresetn = 1'b0;
      tick();
      checkOutput("mid.awvalid", bus.awvalid, 0);
      checkOutput("mid.wvalid", bus.wvalid, 0);
      checkOutput("mid.bready", bus.bready, 0);
      checkOutput("mid.rsp_valid", bus.rsp_valid, 0);
      checkOutput("mid.cmd_ready", bus.cmd_ready, 0);
      checkOutput("mid.err_sticky", errSticky, 0);
      bus.wd_valid = 1'b0; bus.wready = 1'b0;
      aresetn = 1'b1;
      tick();
      checkOutput("mid.cmd_ready_rise", bus.cmd_ready, 1);
      applyStimulus(1'b1, 4'hA, 32'h700, 4'd0);
      checkOutput("post.awaddr", bus.awaddr, 32'h700);
      bus.awready = 1'b1;
      tick();
      bus.awready = 1'b0;
      bus.wd_valid = 1'b1; bus.wd_data = 32'h12345678; bus.wd_strb = 4'h3; bus.wready = 1'b1;
      #1;
      checkOutput("post.wdata", bus.wdata, 32'h12345678);
      checkOutput("post.wstrb", bus.wstrb, 4'h3);
      checkOutput("post.wlast", bus.wlast, 1);
      tick();
      bus.wd_valid = 1'b0; bus.wready = 1'b0;
      bus.bvalid = 1'b1; bus.bid = 4'hA; bus.bresp = RESP_OKAY;
      tick();
      bus.bvalid = 1'b0;
      rspPhase(1'b1, RESP_OKAY, 1'b0, 1'b0, "post");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/axi_master_engine.md
# axi_master_engine

Synthesizable, parametrised AXI3 master transaction engine. It accepts one read or write command at a time on a valid/ready command port. It then runs the full AW/W/B or AR/R handshake sequence with bursts of 1–16 beats, and reports completion on a response port. It streams write data in and read data out, and is intended to drive slave models and DUT slaves in benches.

## Interface
- DATA_WIDTH, 32, AXI data width in bits; one of 32/64/128
- ADDR_WIDTH, 32, AXI address width
- ID_WIDTH, 4, AXI ID width
- STRB_WIDTH, DATA_WIDTH/8, derived; not overridable
- aclk  in  1  clock; all logic on rising edge
- aresetn  in  1  reset; synchronous, active-low
- cmd_valid / cmd_ready  in/out  1  command handshake
- cmd_write  in  1  1 = write, 0 = read
- cmd_id  in  ID_WIDTH  driven on awid/wid or arid
- cmd_addr  in  ADDR_WIDTH  start address
- cmd_len  in  4  beats-1, AXI3 encoding
- cmd_size  in  3  bytes-per-beat code; must be ≤ log2(STRB_WIDTH)
- cmd_burst  in  2  FIXED/INCR/WRAP
- wd_valid / wd_ready  in/out  1  write-data stream handshake
- wd_data / wd_strb  in  DATA_WIDTH / STRB_WIDTH  write beat payload
- rd_valid / rd_ready  out/in  1  read-data stream handshake
- rd_data  out  DATA_WIDTH  read beat
- rd_last  out  1  final beat of the burst
- rsp_valid / rsp_ready  out/in  1  completion handshake
- rsp_write  out  1  completed command type
- rsp_resp  out  2  worst response seen in the burst
- rsp_err  out  1  rsp_resp != OKAY, or an rlast mismatch occurred
- err_sticky  out  1  set on any rsp_err; cleared only by reset
- aw*: awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid  out; awready  in
- w*: wid, wdata, wstrb, wlast, wvalid  out; wready  in
- b*: bid, bresp, bvalid  in; bready  out
- ar*: arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid  out; arready  in
- r*: rid, rdata, rresp, rlast, rvalid  in; rready  out

## Operation
- States: IDLE, AW, W, B, AR, R, RSP.
- **IDLE**
  - cmd_ready = 1.
  - On cmd_valid, latch the command and go to AW (write) or AR (read).
- **AW / AR**
  - Drive valid and the latched fields.
  - Fixed fields: lock = NORMAL, cache = 0, prot = NORMAL.
  - Hold all fields stable until the ready input is sampled high, then go to W / R.
- **W**
  - wvalid = wd_valid and wd_ready = wready, combinational pass-through; wid = the latched ID.
  - Beat counter runs 0..len. wlast = (count == len).
  - When the beat with wlast completes, go to B.
- **B**
  - bready = 1.
  - On bvalid, capture bresp and go to RSP.
  - bid ≠ latched ID sets rsp_err.
- **R**
  - rd_valid = rvalid and rready = rd_ready, pass-through; rd_last = (count == len).
  - Track the worst rresp, ordered DECERR > SLVERR > OKAY.
  - An rlast that disagrees with the count sets rsp_err.
  - After beat len completes, go to RSP.
- **RSP**
  - rsp_valid = 1 until rsp_ready, then go to IDLE.
- Only one command is outstanding at a time.
- The engine never asserts wvalid before the AW handshake completes.

## Timing
- **Reset** (aresetn low at a rising edge):
  - State returns to IDLE.
  - All valid/ready outputs = 0; aw/ar/w payload outputs = 0; rsp_* = 0; err_sticky = 0.
  - cmd_ready rises the cycle after reset is released.
- **Reset mid-operation:** abort immediately with no response; the next cycle behaves as post-reset.
- **Latencies:**
  - Command accepted at edge N → awvalid/arvalid high from N+1.
  - AW handshake at edge M → W state from M+1.
  - Last W beat at edge K → bready high from K+1.
  - bvalid at edge J → rsp_valid from J+1.
  - Read path: last R beat at edge K → rsp_valid from K+1.
- **Back-to-back:** rsp handshake at edge P → cmd_ready high from P+1. Minimum single-beat write = 4 cycles of overhead plus slave latency.
- **Data stalls:** wd_valid low inserts wvalid bubbles; rd_ready low holds rready low. No beat is lost or duplicated.
- **Early response:** a bvalid arriving during W is ignored until state B; bready stays low.

## Structure
- Shared package axi_pkg holds:
  - burst-type constants (FIXED/INCR/WRAP);
  - response codes (OKAY/EXOKAY/SLVERR/DECERR);
  - lock and protection encodings;
  - the state enum;
  - the response-severity compare function.
- No sub-module is needed; the FSM, beat counter and response merge stay in one module.

## Test plan
- **Single write:** cmd write addr 0x100, len 0, data 0xDEADBEEF, strb 0xF; slave awready after 2 cycles, bresp OKAY → one W beat with wlast = 1; rsp_valid with resp 0, err 0.
- **INCR4 read:** addr 0x200, slave returns 0x11/0x22/0x33/0x44 with rlast on beat 4 → rd_data in order, rd_last only on beat 4, rsp_resp OKAY.
- **Backpressure:** 8-beat write with wd_valid toggling every cycle and wready low for 3 cycles → exactly 8 W beats, all fields stable while stalled.
- **Error path:** read len 1 where beat 1 returns SLVERR and beat 2 returns DECERR → rsp_resp = DECERR, rsp_err = 1, err_sticky stays 1 through a following OKAY transaction.
- **rlast mismatch:** len 3 read with rlast asserted on beat 2 → rsp_err = 1.
- **Reset mid-burst:** aresetn low during beat 2 of an INCR4 write → next cycle all valids are 0, state IDLE, no rsp_valid; a following command completes normally.
